instr_cache_assoc: RTL

//  Parametrised set-associative instruction cache for the fetch stage, between PC/fetch and the memory arbiter.

---
 rtl/instr_cache_pkg.sv | 26 ++
 rtl/instr_cache_plru.sv | 72 +++++++
 rtl/instr_cache_assoc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: shared state encoding and address-split width helpers for the instruction cache.
package instr_cache_pkg;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_e;

    // Byte-offset width within a line.
    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Set-index width; zero for a single-set cache.
    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag width: whatever remains above offset and index.
    function automatic int tag_w(input int addr_w, input int line_bytes, input int num_sets);
        return addr_w - off_w(line_bytes) - idx_w(num_sets);
    endfunction

    // Word-select width within a line; zero for one-word lines.
    function automatic int word_sel_w(input int line_bytes);
        return off_w(line_bytes) - 2;
    endfunction

endpackage

// File: rtl/instr_cache_plru.sv
// instr_cache_plru: per-set tree-PLRU state with a touch port and a victim lookup port.
//   clk, reset     clock, asynchronous active-high reset (all bits to 0)
//   clear          synchronous clear of every set's tree
//   touch_en       mark touch_way of touch_set as most recently used
//   victim_set     set whose pseudo-LRU way is reported on victim_way
module instr_cache_plru
    import instr_cache_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 2,
    localparam int IDX_W   = idx_w(NUM_SETS) > 0 ? idx_w(NUM_SETS) : 1,
    localparam int WAY_W   = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             touch_en,
    input  logic [IDX_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic [IDX_W-1:0] victim_set,
    output logic [WAY_W-1:0] victim_way
);
    localparam int LEVELS = $clog2(NUM_WAYS);

    // Heap-ordered tree nodes (root 0, children 2n+1 / 2n+2); a 0 bit steers the victim left.
    // One spare bit keeps the row indexable for every legal way count.
    logic [NUM_WAYS-1:0] plru_q [NUM_SETS];
    logic [NUM_WAYS-1:0] plru_d [NUM_SETS];

    always_comb begin : touch_logic
        logic [NUM_WAYS-1:0] row;
        logic                b;
        int                  node;
        plru_d = plru_q;
        row    = plru_q[touch_set];
        node   = 0;
        // Each node on the path is pointed away from the touched way.
        for (int l = 0; l < LEVELS; l++) begin
            b                    = touch_way[WAY_W'(LEVELS - 1 - l)];
            row[WAY_W'(node)]    = !b;
            node                 = 2 * node + 1 + int'(b);
        end
        if (clear) begin
            for (int s = 0; s < NUM_SETS; s++) plru_d[s] = '0;
        end else if (touch_en) begin
            plru_d[touch_set] = row;
        end
    end

    always_comb begin : victim_logic
        logic [NUM_WAYS-1:0] row;
        logic                b;
        int                  node;
        victim_way = '0;
        row        = plru_q[victim_set];
        node       = 0;
        for (int l = 0; l < LEVELS; l++) begin
            b                                  = row[WAY_W'(node)];
            victim_way[WAY_W'(LEVELS - 1 - l)] = b;
            node                               = 2 * node + 1 + int'(b);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else begin
            plru_q <= plru_d;
        end
    end

endmodule

// File: rtl/instr_cache_assoc.sv
// instr_cache_assoc: set-associative instruction cache with same-cycle hits, blocking line refill and tree-PLRU.
//   clk, reset                 clock, asynchronous active-high reset
//   flush                      invalidate every line; an in-flight refill is drained and discarded
//   mem_read, address          fetch request and byte address
//   readdata, cache_hit        instruction word and combinational hit flag
//   reqI_mem, reqAddrI_mem     level-held refill request and its line address
//   data_from_mem, read_ready_from_mem   refill line and its one-cycle valid pulse
//   hit_count, miss_count      saturating performance counters
module instr_cache_assoc
    import instr_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int COUNT_W    = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 mem_read,
    input  logic [ADDR_W-1:0]                    address,
    output logic [31:0]                          readdata,
    output logic                                 cache_hit,
    output logic                                 reqI_mem,
    output logic [ADDR_W-off_w(LINE_BYTES)-1:0]  reqAddrI_mem,
    input  logic [8*LINE_BYTES-1:0]              data_from_mem,
    input  logic                                 read_ready_from_mem,
    output logic [COUNT_W-1:0]                   hit_count,
    output logic [COUNT_W-1:0]                   miss_count
);
    localparam int OFF_W    = off_w(LINE_BYTES);
    localparam int LA_W     = ADDR_W - OFF_W;
    localparam int IDX_BITS = idx_w(NUM_SETS);
    localparam int IDX_W    = IDX_BITS > 0 ? IDX_BITS : 1;
    localparam int TAG_W    = tag_w(ADDR_W, LINE_BYTES, NUM_SETS);
    localparam int WSEL_W   = word_sel_w(LINE_BYTES) > 0 ? word_sel_w(LINE_BYTES) : 1;
    localparam int WAY_W    = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_W   = 8 * LINE_BYTES;
    localparam int WORDS    = LINE_BYTES / 4;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [LA_W-1:0]     line_q, line_d;
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
    logic [COUNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;

    // Data and tag storage carry no reset; valid bits gate every use.
    logic [LINE_W-1:0]   data_q [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_q  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]    idx, fill_set, touch_set;
    logic [TAG_W-1:0]    tag, fill_tag;
    logic [WSEL_W-1:0]   word;
    logic [NUM_WAYS-1:0] match;
    logic [WAY_W-1:0]    hit_way, vict_way, plru_way, touch_way;
    logic [31:0]         words [WORDS];
    logic                fill_en, touch_en, plru_clear;

    // Masking with (N-1) makes the split correct for single-set and one-word-line configurations.
    assign idx      = IDX_W'((address >> OFF_W) & (NUM_SETS - 1));
    assign tag      = TAG_W'(address >> (OFF_W + IDX_BITS));
    assign word     = WSEL_W'((address >> 2) & (WORDS - 1));
    assign fill_set = IDX_W'(line_q & LA_W'(NUM_SETS - 1));
    assign fill_tag = TAG_W'(line_q >> IDX_BITS);

    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
            if (match[w]) hit_way = WAY_W'(w);
        end
    end

    assign cache_hit = mem_read && (state_q == IDLE) && !flush && (|match);

    always_comb begin
        for (int i = 0; i < WORDS; i++) words[i] = data_q[idx][hit_way][i*32 +: 32];
    end

    assign readdata = cache_hit ? words[word] : 32'd0;

    // Lowest-index invalid way wins; PLRU only decides once the set is full.
    always_comb begin
        vict_way = plru_way;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[fill_set][w]) vict_way = WAY_W'(w);
        end
    end

    assign touch_set = (state_q == IDLE) ? idx : fill_set;
    assign touch_way = (state_q == IDLE) ? hit_way : vict_way;

    instr_cache_plru #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .clk        (clk),
        .reset      (reset),
        .clear      (plru_clear),
        .touch_en   (touch_en),
        .touch_set  (touch_set),
        .touch_way  (touch_way),
        .victim_set (fill_set),
        .victim_way (plru_way)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        line_d     = line_q;
        valid_d    = valid_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        fill_en    = 1'b0;
        touch_en   = 1'b0;
        plru_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    for (int s = 0; s < NUM_SETS; s++) valid_d[s] = '0;
                    plru_clear = 1'b1;
                end else if (cache_hit) begin
                    touch_en = 1'b1;
                    hit_d    = (&hit_q) ? hit_q : hit_q + 1'b1;
                end else if (mem_read) begin
                    line_d  = address[ADDR_W-1:OFF_W];
                    req_d   = 1'b1;
                    miss_d  = (&miss_q) ? miss_q : miss_q + 1'b1;
                    state_d = MISS;
                end
            end
            MISS: begin
                if (flush) begin
                    // Arriving data is dropped; otherwise wait for it in DRAIN.
                    for (int s = 0; s < NUM_SETS; s++) valid_d[s] = '0;
                    state_d = read_ready_from_mem ? IDLE : DRAIN;
                    req_d   = !read_ready_from_mem;
                end else if (read_ready_from_mem) begin
                    fill_en                     = 1'b1;
                    touch_en                    = 1'b1;
                    valid_d[fill_set][vict_way] = 1'b1;
                    req_d                       = 1'b0;
                    state_d                     = IDLE;
                end
            end
            DRAIN: begin
                if (flush) begin
                    for (int s = 0; s < NUM_SETS; s++) valid_d[s] = '0;
                end
                if (read_ready_from_mem) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            line_q  <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            line_q  <= line_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[fill_set][vict_way] <= data_from_mem;
            tag_q[fill_set][vict_way]  <= fill_tag;
        end
    end

    assign reqI_mem     = req_q;
    assign reqAddrI_mem = line_q;
    assign hit_count    = hit_q;
    assign miss_count   = miss_q;

    a_one_way_match: assert property (@(posedge clk) disable iff (reset) $onehot0(match))
        else $error("instr_cache_assoc: multiple ways hit in one set");

endmodule
